// File: rtl/rom_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to the
// instruction ROM, verifies a trailing additive checksum, and releases the core on success.
module rom_loader #(
  parameter int ROMADDRWIDTH = 10
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [ROMADDRWIDTH:0]   length,
  input  logic                    bytevalid,
  input  logic [7:0]              bytedata,
  output logic                    byteready,
  output logic                    romwrite,
  output logic [ROMADDRWIDTH-1:0] romaddress,
  output logic [31:0]             romwdata,
  output logic                    corenreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam logic [ROMADDRWIDTH:0] MAX_LEN = {1'b1, {ROMADDRWIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, FAIL} state_t;

  state_t state_reg, state_next;

  logic [1:0]            byte_cnt_reg;
  logic [ROMADDRWIDTH:0] word_cnt_reg;
  logic [ROMADDRWIDTH:0] len_reg;
  logic [31:0]           asm_reg;
  logic [31:0]           checksum_reg;

  logic        streaming;
  logic        accept;
  logic        word_done;
  logic        start_ok;
  logic        len_legal;
  logic        load_word;
  logic [31:0] word_full;

  logic byteready_next, corenreset_next, busy_next, done_next, error_next;

  assign streaming = (state_reg == LOAD) || (state_reg == CHECK);
  assign accept    = bytevalid && streaming;
  assign word_done = accept && (byte_cnt_reg == 2'd3);
  assign load_word = word_done && (state_reg == LOAD);
  assign start_ok  = start && !streaming;
  assign len_legal = (length != '0) && (length <= MAX_LEN);
  // New byte enters at the top; after four shifts the first byte sits in [7:0].
  assign word_full = {bytedata, asm_reg[31:8]};

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RUN, FAIL: begin
        if (start) state_next = len_legal ? LOAD : FAIL;
      end
      LOAD: begin
        if (word_done && (word_cnt_reg + 1'b1 == len_reg)) state_next = CHECK;
      end
      CHECK: begin
        if (word_done) state_next = (word_full == checksum_reg) ? RUN : FAIL;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic, evaluated on the upcoming state so every output is a register
  always_comb begin
    byteready_next  = (state_next == LOAD) || (state_next == CHECK);
    busy_next       = byteready_next;
    corenreset_next = (state_next == RUN);
    done_next       = (state_next == RUN);
    error_next      = (state_next == FAIL);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      byteready  <= 1'b0;
      busy       <= 1'b0;
      corenreset <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byteready  <= byteready_next;
      busy       <= busy_next;
      corenreset <= corenreset_next;
      done       <= done_next;
      error      <= error_next;
    end
  end

  // Byte assembly, word counting and checksum accumulation
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      len_reg      <= '0;
      asm_reg      <= '0;
      checksum_reg <= '0;
    end else if (start_ok) begin
      if (len_legal) begin
        len_reg      <= length;
        byte_cnt_reg <= '0;
        word_cnt_reg <= '0;
        checksum_reg <= '0;
      end
    end else if (accept) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      asm_reg      <= word_full;
      if (load_word) begin
        checksum_reg <= checksum_reg + word_full;
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
    end
  end

  // ROM write port; address and data hold between strobes
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      romwrite   <= 1'b0;
      romaddress <= '0;
      romwdata   <= '0;
    end else begin
      romwrite <= load_word;
      if (load_word) begin
        romaddress <= word_cnt_reg[ROMADDRWIDTH-1:0];
        romwdata   <= word_full;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized and directed bench for rom_loader; a word-list reference model predicts ROM
// writes and the checksum verdict.
module tb_rom_loader;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          bytevalid = 1'b0;
  logic [7:0]    bytedata = '0;
  logic          byteready;
  logic          romwrite;
  logic [AW-1:0] romaddress;
  logic [31:0]   romwdata;
  logic          corenreset;
  logic          busy;
  logic          done;
  logic          error;

  rom_loader #(.ROMADDRWIDTH(AW)) dut (
    .clock(clock), .nreset(nreset), .start(start), .length(length),
    .bytevalid(bytevalid), .bytedata(bytedata), .byteready(byteready),
    .romwrite(romwrite), .romaddress(romaddress), .romwdata(romwdata),
    .corenreset(corenreset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] words[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clock) begin
    if (romwrite) begin
      got_addr.push_back(32'(romaddress));
      got_data.push_back(romwdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = (AW+1)'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    bytevalid = 1'b0;
    repeat (gap) tick();
    bytevalid = 1'b1;
    bytedata  = b;
    taken = 1'b0;
    for (int i = 0; i < 50 && !taken; i++) begin
      if (byteready) taken = 1'b1;
      tick();
    end
    if (!taken) check("byte_timeout", 32'd0, 32'd1);
    bytevalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    logic [31:0] v;
    v = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(v[7:0], $urandom_range(maxgap, 0));
      v = v >> 8;
    end
  endtask

  // Loads the current word list; cs_xor != 0 corrupts the transmitted checksum.
  task automatic run_load(input string name, input logic [31:0] cs_xor, input int maxgap,
                          input bit poke_start);
    logic [31:0] sum;
    bit          exp_ok;
    int          n;
    n = words.size();
    sum = 32'd0;
    foreach (words[i]) sum = sum + words[i];
    exp_ok = (cs_xor == 32'd0);
    got_addr.delete();
    got_data.delete();

    do_start(n);
    check({name, "_ready_after_start"}, 32'(byteready), 32'd1);
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_corenreset_after_start"}, 32'(corenreset), 32'd0);

    for (int i = 0; i < n; i++) begin
      send_word(words[i], maxgap);
      if (poke_start && i == 0) begin
        start  = 1'b1;
        length = '0;
        tick();
        start = 1'b0;
        check({name, "_start_ignored_busy"}, 32'(busy), (n > 1) ? 32'd1 : 32'd1);
        check({name, "_start_ignored_error"}, 32'(error), 32'd0);
      end
    end
    send_word(sum ^ cs_xor, maxgap);

    check({name, "_done"}, 32'(done), 32'(exp_ok));
    check({name, "_error"}, 32'(error), 32'(!exp_ok));
    check({name, "_corenreset"}, 32'(corenreset), 32'(exp_ok));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_ready_end"}, 32'(byteready), 32'd0);
    check({name, "_wr_count"}, 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check({name, "_wr_addr"}, got_addr[i], 32'(i));
      check({name, "_wr_data"}, got_data[i], words[i]);
    end
    $display("load %s len=%0d gap<=%0d done=%0b error=%0b writes=%0d",
             name, n, maxgap, done, error, got_addr.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byteready"}, 32'(byteready), 32'd0);
    check({tag, "_romwrite"}, 32'(romwrite), 32'd0);
    check({tag, "_romaddress"}, 32'(romaddress), 32'd0);
    check({tag, "_romwdata"}, romwdata, 32'd0);
    check({tag, "_corenreset"}, 32'(corenreset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic illegal_len(input int len);
    got_addr.delete();
    do_start(len);
    check("illegal_error", 32'(error), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    bytevalid = 1'b1;
    bytedata  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      check("illegal_ready", 32'(byteready), 32'd0);
      tick();
    end
    bytevalid = 1'b0;
    check("illegal_no_write", 32'(got_addr.size()), 32'd0);
    $display("start illegal len=%0d error=%0b", len, error);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();

    // Nominal two-word load
    words = '{32'h00500093, 32'h00100113};
    run_load("nominal", 32'd0, 0, 1'b0);

    // Bad checksum (A7 instead of A6 in the low byte)
    run_load("badsum", 32'h00000001, 0, 1'b0);

    illegal_len(0);
    illegal_len((1 << AW) + 1);

    // Throttled: bytevalid low every other cycle, start poked during LOAD
    words = '{32'h00500093, 32'h00100113};
    run_load("throttled", 32'd0, 1, 1'b1);

    // Reset after five bytes
    got_addr.delete();
    do_start(2);
    send_word(32'h00500093, 0);
    send_byte(8'h13, 0);
    nreset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    nreset = 1'b1;
    tick();
    $display("reset mid-load done=%0b error=%0b", done, error);
    run_load("after_reset", 32'd0, 0, 1'b0);

    // Reload from RUN with a single word
    words = '{32'h00500093};
    run_load("reload", 32'd0, 0, 1'b0);

    // Randomized loads
    for (int t = 0; t < 20; t++) begin
      int n;
      logic [31:0] cx;
      n = $urandom_range(8, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      cx = ($urandom_range(3, 0) == 0) ? (32'd1 << $urandom_range(31, 0)) : 32'd0;
      run_load("random", cx, $urandom_range(2, 0), 1'(t % 5 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader sitting upstream of the `riscv32s` instruction ROM. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them sequentially into the ROM, and verifies a trailing 32-bit checksum. Holds the core in reset until a load completes with a matching checksum, then releases it.

## Interface
- `ROMADDRWIDTH`, 10: ROM word-address width; ROM depth is 2**ROMADDRWIDTH words.

- `clock`  in  1  system clock, rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN or FAIL.
- `length`  in  ROMADDRWIDTH+1  number of instruction words to load; sampled on an accepted `start`.
- `bytevalid`  in  1  upstream byte is valid.
- `bytedata`  in  8  upstream byte.
- `byteready`  out  1  loader can accept a byte this cycle.
- `romwrite`  out  1  ROM write strobe, one cycle per word.
- `romaddress`  out  ROMADDRWIDTH  ROM word address.
- `romwdata`  out  32  ROM write data.
- `corenreset`  out  1  active-low reset to the core; high only in RUN.
- `busy`  out  1  high in LOAD and CHECK.
- `done`  out  1  high in RUN.
- `error`  out  1  high in FAIL.

## Operation
- States: IDLE, LOAD, CHECK, RUN, FAIL. Reset enters IDLE.
- IDLE/RUN/FAIL + `start`: if `length` == 0 or `length` > 2**ROMADDRWIDTH, go to FAIL; otherwise latch `length`, clear byte counter, word counter and checksum, and go to LOAD.
- `start` is ignored in LOAD and CHECK.
- A byte is accepted on a rising edge with `bytevalid` && `byteready`. `byteready` is high exactly in LOAD and CHECK. Bytes offered in any other state are not consumed.
- LOAD: accepted bytes fill word bits [7:0], [15:8], [23:16], [31:24] in order. On the 4th byte, the word is written to address = word counter. The checksum accumulates `checksum + word` mod 2**32 and the word counter increments. When the word counter reaches `length`, go to CHECK.
- CHECK: 4 bytes are assembled little-endian into the expected checksum. On the 4th byte, go to RUN if it equals the accumulated checksum, else go to FAIL.
- RUN: `corenreset`=1, `done`=1. FAIL: `corenreset`=0, `error`=1.
- A restart from RUN drops `corenreset` to 0 on the edge that accepts `start`.
- ROM contents beyond `length` are not written.

## Timing
- All outputs are registered. Reset values: `byteready`=0, `romwrite`=0, `romaddress`=0, `romwdata`=0, `corenreset`=0, `busy`=0, `done`=0, `error`=0.
- The edge that accepts `start` sets the next state. `byteready` and `busy` are high from the following cycle.
- Write timing: if the 4th byte of word k is accepted at edge N, then for the cycle after edge N, `romwrite`=1, `romaddress`=k and `romwdata`=the word. `romwrite` returns to 0 at edge N+1.
- `romaddress` and `romwdata` hold their last values while `romwrite`=0.
- Maximum throughput is one byte per cycle; there are no bubbles between words or between LOAD and CHECK.
- CHECK resolution: if the final checksum byte is accepted at edge M, then after edge M `byteready`=0, `busy`=0, and either `done`=`corenreset`=1 or `error`=1.
- Asserting `nreset` mid-load aborts immediately to IDLE with all outputs at reset values. The partially loaded ROM contents are left as-is.
- Gaps in `bytevalid` stall the loader indefinitely, with no timeout.

## Test plan
- Nominal two-word load: `start` with `length`=2, then bytes 93 00 50 00 13 01 10 00 and checksum bytes A6 01 60 00. Expect ROM writes (0, 0x00500093) and (1, 0x00100113), then `done`=1 and `corenreset`=1.
- Bad checksum: same stream with checksum bytes A7 01 60 00. Expect both ROM writes, then `error`=1, `corenreset`=0 and `done`=0.
- Illegal length: `start` with `length`=0, and separately with `length`=2**ROMADDRWIDTH+1. Expect FAIL on the next cycle, no `romwrite`, and `byteready`=0 throughout.
- Throttled handshake: nominal stream with `bytevalid` toggling every other cycle and bytes held while not accepted. Expect ROM writes and the final result identical to the nominal case. Also `start` pulsed during LOAD must be ignored.
- Reset mid-operation: drop `nreset` after 5 bytes of the nominal stream. Expect all outputs at reset values immediately; then rerun the nominal load and expect success.
- Reload from RUN: after a nominal success, pulse `start` with `length`=1, send bytes 93 00 50 00 and checksum 93 00 50 00. Expect `corenreset` to drop on the accepting edge, one write (0, 0x00500093), then `done`=1 again.
